// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the CPU fetch / load-store RAM arbiter.
package mem_arbiter_pkg;

  localparam int XLEN_DEF       = 32;
  localparam int ADDR_WIDTH_DEF = 12;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ACC_I = 2'd1,
    ARB_ACC_D = 2'd2
  } arb_state_e;

  // Byte, aligned halfword and full word lane patterns are the only legal data masks.
  function automatic logic mask_legal(input logic [3:0] mask);
    case (mask)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_access_check.sv
// Combinational legality check of one port's request: range, alignment (fetch) or lane mask (data).
module mem_arbiter_access_check
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic [31:0] addr,
  input  logic [3:0]  mask,
  input  logic        isFetch,
  output logic        err
);

  logic out_of_range;

  assign out_of_range = |addr[31:ADDR_WIDTH+2];

  always_comb begin
    err = out_of_range;
    if (isFetch) begin
      err = out_of_range | (|addr[1:0]);
    end else begin
      err = out_of_range | ~mask_legal(mask);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the CPU fetch and load/store ports onto one single-port synchronous RAM,
// with a fixed one-cycle grant-to-ack latency and error acks for illegal requests.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  iReq,
  input  logic [XLEN-1:0]       iAddr,
  output logic                  iAck,
  output logic [XLEN-1:0]       iRData,
  output logic                  iErr,
  input  logic                  dReq,
  input  logic                  dWr,
  input  logic [XLEN-1:0]       dAddr,
  input  logic [XLEN-1:0]       dWData,
  input  logic [XLEN/8-1:0]     dMask,
  output logic                  dAck,
  output logic [XLEN-1:0]       dRData,
  output logic                  dErr,
  output logic                  ramEn,
  output logic                  ramWe,
  output logic [ADDR_WIDTH-1:0] ramAddr,
  output logic [XLEN/8-1:0]     ramWrMask,
  output logic [XLEN-1:0]       ramWData,
  input  logic [XLEN-1:0]       ramRData
);

  arb_state_e state_q, state_d;
  logic       i_err_q, i_err_d;
  logic       d_err_q, d_err_d;
  logic       grant_i, grant_d;
  logic       i_chk_err, d_chk_err;

  mem_arbiter_access_check #(.ADDR_WIDTH(ADDR_WIDTH)) u_check_i (
    .addr    (iAddr),
    .mask    (4'b1111),
    .isFetch (1'b1),
    .err     (i_chk_err)
  );

  mem_arbiter_access_check #(.ADDR_WIDTH(ADDR_WIDTH)) u_check_d (
    .addr    (dAddr),
    .mask    (dMask),
    .isFetch (1'b0),
    .err     (d_chk_err)
  );

  // A port in its own ack cycle is never eligible, which forces alternation under contention.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (iReq && dReq) begin
          grant_d = DATA_FIRST;
          grant_i = ~DATA_FIRST;
        end else begin
          grant_i = iReq;
          grant_d = dReq;
        end
      end
      ARB_ACC_I: grant_d = dReq;
      ARB_ACC_D: grant_i = iReq;
      default: ;
    endcase
    state_d = grant_d ? ARB_ACC_D : (grant_i ? ARB_ACC_I : ARB_IDLE);
    i_err_d = grant_i & i_chk_err;
    d_err_d = grant_d & d_chk_err;
  end

  always_comb begin
    ramEn     = 1'b0;
    ramWe     = 1'b0;
    ramAddr   = '0;
    ramWrMask = '0;
    ramWData  = '0;
    if (grant_d && !d_chk_err) begin
      ramEn   = reset;
      ramWe   = reset & dWr;
      ramAddr = dAddr[ADDR_WIDTH+1:2];
      if (dWr) begin
        ramWrMask = dMask;
        ramWData  = dWData;
      end
    end else if (grant_i && !i_chk_err) begin
      ramEn   = reset;
      ramAddr = iAddr[ADDR_WIDTH+1:2];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
      i_err_q <= 1'b0;
      d_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      i_err_q <= i_err_d;
      d_err_q <= d_err_d;
    end
  end

  assign iAck   = (state_q == ARB_ACC_I);
  assign dAck   = (state_q == ARB_ACC_D);
  assign iErr   = iAck & i_err_q;
  assign dErr   = dAck & d_err_q;
  assign iRData = (iAck && !i_err_q) ? ramRData : '0;
  assign dRData = (dAck && !d_err_q && !dWr) ? ramRData : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: two instances (data-first and fetch-first), each with its own RAM model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        iReq, dReq, dWr;
  logic        i0Req, d0Req;
  logic [31:0] iAddr, dAddr, dWData;
  logic [3:0]  dMask;

  logic        iAck, iErr, dAck, dErr, ramEn, ramWe;
  logic [31:0] iRData, dRData, ramWData, ramRData;
  logic [11:0] ramAddr;
  logic [3:0]  ramWrMask;

  logic        iAck0, iErr0, dAck0, dErr0, ramEn0, ramWe0;
  logic [31:0] iRData0, dRData0, ramWData0, ramRData0;
  logic [11:0] ramAddr0;
  logic [3:0]  ramWrMask0;

  logic [31:0] mem  [0:4095];
  logic [31:0] mem0 [0:4095];
  logic        memInit = 1'b0;
  logic        mem0Init = 1'b0;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.XLEN(32), .ADDR_WIDTH(12), .DATA_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset),
    .iReq(iReq), .iAddr(iAddr), .iAck(iAck), .iRData(iRData), .iErr(iErr),
    .dReq(dReq), .dWr(dWr), .dAddr(dAddr), .dWData(dWData), .dMask(dMask),
    .dAck(dAck), .dRData(dRData), .dErr(dErr),
    .ramEn(ramEn), .ramWe(ramWe), .ramAddr(ramAddr), .ramWrMask(ramWrMask),
    .ramWData(ramWData), .ramRData(ramRData)
  );

  mem_arbiter #(.XLEN(32), .ADDR_WIDTH(12), .DATA_FIRST(1'b0)) dut0 (
    .clk(clk), .reset(reset),
    .iReq(i0Req), .iAddr(iAddr), .iAck(iAck0), .iRData(iRData0), .iErr(iErr0),
    .dReq(d0Req), .dWr(dWr), .dAddr(dAddr), .dWData(dWData), .dMask(dMask),
    .dAck(dAck0), .dRData(dRData0), .dErr(dErr0),
    .ramEn(ramEn0), .ramWe(ramWe0), .ramAddr(ramAddr0), .ramWrMask(ramWrMask0),
    .ramWData(ramWData0), .ramRData(ramRData0)
  );

  // Synchronous byte-writable RAMs, read-before-write, preloaded on the first clock edge.
  always @(posedge clk) begin
    if (!memInit) begin
      for (int w = 0; w < 4096; w++) mem[w] <= 32'h0;
      mem[0]  <= 32'h0BADF00D;
      mem[4]  <= 32'hDEADBEEF;
      memInit <= 1'b1;
    end else if (ramEn) begin
      ramRData <= mem[ramAddr];
      for (int b = 0; b < 4; b++)
        if (ramWe && ramWrMask[b]) mem[ramAddr][8*b +: 8] <= ramWData[8*b +: 8];
    end
  end

  always @(posedge clk) begin
    if (!mem0Init) begin
      for (int w = 0; w < 4096; w++) mem0[w] <= 32'h0;
      mem0[0]  <= 32'h0BADF00D;
      mem0[4]  <= 32'hDEADBEEF;
      mem0Init <= 1'b1;
    end else if (ramEn0) begin
      ramRData0 <= mem0[ramAddr0];
      for (int b = 0; b < 4; b++)
        if (ramWe0 && ramWrMask0[b]) mem0[ramAddr0][8*b +: 8] <= ramWData0[8*b +: 8];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) begin
      passes++;
    end else begin
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                               input logic [31:0] da, input logic [31:0] dd, input logic [3:0] dm);
    iReq   = ir;
    iAddr  = ia;
    dReq   = dr;
    dWr    = dw;
    dAddr  = da;
    dWData = dd;
    dMask  = dm;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    i0Req = 1'b0;
    d0Req = 1'b0;
    applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 4'b1111);

    // Reset held with both ports requesting
    tick();
    checkOutput("rst_iAck", iAck, 1'b0);
    checkOutput("rst_dAck", dAck, 1'b0);
    checkOutput("rst_ramEn", ramEn, 1'b0);
    checkOutput("rst_ramWe", ramWe, 1'b0);

    // Release reset into a single fetch of word 4
    reset = 1'b1;
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'b1111);
    #1;
    checkOutput("fetch_ramEn", ramEn, 1'b1);
    checkOutput("fetch_ramAddr", ramAddr, 32'd4);
    checkOutput("fetch_ramWe", ramWe, 1'b0);
    tick();
    checkOutput("fetch_iAck", iAck, 1'b1);
    checkOutput("fetch_iRData", iRData, 32'hDEADBEEF);
    checkOutput("fetch_iErr", iErr, 1'b0);
    checkOutput("fetch_ackcycle_ramEn", ramEn, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b1111);
    tick();
    checkOutput("idle_iAck", iAck, 1'b0);

    // Tie with data-first: store wins, then fetch
    applyStimulus(1'b1, 32'h0, 1'b1, 1'b1, 32'h20, 32'h12345678, 4'b1111);
    #1;
    checkOutput("tie1_c0_ramWe", ramWe, 1'b1);
    checkOutput("tie1_c0_ramAddr", ramAddr, 32'd8);
    checkOutput("tie1_c0_ramWrMask", ramWrMask, 32'hF);
    checkOutput("tie1_c0_ramWData", ramWData, 32'h12345678);
    tick();
    checkOutput("tie1_c1_dAck", dAck, 1'b1);
    checkOutput("tie1_c1_dErr", dErr, 1'b0);
    checkOutput("tie1_c1_dRData", dRData, 32'h0);
    checkOutput("tie1_c1_ramEn", ramEn, 1'b1);
    checkOutput("tie1_c1_ramWe", ramWe, 1'b0);
    checkOutput("tie1_c1_ramAddr", ramAddr, 32'd0);
    dReq = 1'b0;
    dWr  = 1'b0;
    tick();
    checkOutput("tie1_c2_iAck", iAck, 1'b1);
    checkOutput("tie1_c2_iRData", iRData, 32'h0BADF00D);
    checkOutput("tie1_c2_dAck", dAck, 1'b0);
    iReq = 1'b0;
    tick();

    // Same tie on the fetch-first instance: fetch, then store
    i0Req = 1'b1;
    d0Req = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h20, 32'h12345678, 4'b1111);
    #1;
    checkOutput("tie0_c0_ramEn", ramEn0, 1'b1);
    checkOutput("tie0_c0_ramWe", ramWe0, 1'b0);
    checkOutput("tie0_c0_ramAddr", ramAddr0, 32'd0);
    tick();
    checkOutput("tie0_c1_iAck", iAck0, 1'b1);
    checkOutput("tie0_c1_iRData", iRData0, 32'h0BADF00D);
    checkOutput("tie0_c1_ramWe", ramWe0, 1'b1);
    checkOutput("tie0_c1_ramAddr", ramAddr0, 32'd8);
    i0Req = 1'b0;
    tick();
    checkOutput("tie0_c2_dAck", dAck0, 1'b1);
    checkOutput("tie0_c2_dErr", dErr0, 1'b0);
    d0Req = 1'b0;
    tick();

    // Byte store into lane 2 of word 8, then read the whole word back
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h22, 32'h00AB0000, 4'b0100);
    #1;
    checkOutput("byte_ramWrMask", ramWrMask, 32'h4);
    checkOutput("byte_ramAddr", ramAddr, 32'd8);
    tick();
    checkOutput("byte_dAck", dAck, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b1111);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 4'b1111);
    #1;
    checkOutput("load_ramWe", ramWe, 1'b0);
    checkOutput("load_ramWrMask", ramWrMask, 32'h0);
    tick();
    checkOutput("load_dAck", dAck, 1'b1);
    checkOutput("load_dRData", dRData, 32'h12AB5678);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b1111);
    tick();

    // Misaligned fetch
    applyStimulus(1'b1, 32'h6, 1'b0, 1'b0, 32'h0, 32'h0, 4'b1111);
    #1;
    checkOutput("ifmis_ramEn", ramEn, 1'b0);
    tick();
    checkOutput("ifmis_iAck", iAck, 1'b1);
    checkOutput("ifmis_iErr", iErr, 1'b1);
    checkOutput("ifmis_iRData", iRData, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b1111);
    tick();

    // Out-of-range fetch at the first illegal byte address
    applyStimulus(1'b1, 32'h4000, 1'b0, 1'b0, 32'h0, 32'h0, 4'b1111);
    #1;
    checkOutput("ifoor_ramEn", ramEn, 1'b0);
    tick();
    checkOutput("ifoor_iErr", iErr, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b1111);
    tick();

    // Illegal mask store
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 32'hFFFFFFFF, 4'b0110);
    #1;
    checkOutput("badmask_ramEn", ramEn, 1'b0);
    checkOutput("badmask_ramWe", ramWe, 1'b0);
    tick();
    checkOutput("badmask_dAck", dAck, 1'b1);
    checkOutput("badmask_dErr", dErr, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b1111);
    tick();

    // Out-of-range store whose truncated word address would alias word 0
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h4000, 32'hFFFFFFFF, 4'b1111);
    #1;
    checkOutput("door_ramWe", ramWe, 1'b0);
    tick();
    checkOutput("door_dErr", dErr, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b1111);
    tick();

    // Word 0 must be untouched by the rejected stores
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 4'b1111);
    tick();
    checkOutput("nowrite_dRData", dRData, 32'h0BADF00D);
    checkOutput("nowrite_dErr", dErr, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b1111);
    tick();

    // Highest legal word address
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h3FFC, 32'h0, 4'b1111);
    #1;
    checkOutput("top_ramEn", ramEn, 1'b1);
    checkOutput("top_ramAddr", ramAddr, 32'hFFF);
    tick();
    checkOutput("top_dErr", dErr, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b1111);
    tick();

    // Continuous contention: acks alternate data, fetch, data ...
    applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0, 4'b1111);
    for (int k = 1; k <= 10; k++) begin
      tick();
      checkOutput($sformatf("b2b_dAck_%0d", k), dAck, (k % 2 == 1) ? 32'd1 : 32'd0);
      checkOutput($sformatf("b2b_iAck_%0d", k), iAck, (k % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("b2b_dRData_%0d", k), dRData, (k % 2 == 1) ? 32'hDEADBEEF : 32'h0);
      checkOutput($sformatf("b2b_iRData_%0d", k), iRData, (k % 2 == 0) ? 32'h0BADF00D : 32'h0);
    end

    // Reset mid-stream drops the pending ack immediately
    reset = 1'b0;
    #1;
    checkOutput("midrst_iAck", iAck, 1'b0);
    checkOutput("midrst_dAck", dAck, 1'b0);
    checkOutput("midrst_ramEn", ramEn, 1'b0);
    tick();
    reset = 1'b1;
    #1;
    checkOutput("postrst_ramEn", ramEn, 1'b1);
    checkOutput("postrst_ramAddr", ramAddr, 32'd4);
    tick();
    checkOutput("postrst_dAck", dAck, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b1111);
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
